// File: rtl/rf_writeback_buffer.sv
// rf_writeback_buffer
//   Write-side producer for the register file. Results from LANES execution
//   lanes are accepted over per-lane valid/ready handshakes and queued in
//   per-lane FIFOs. Each cycle the FIFO heads are arbitrated so that at most
//   one RF write port targets a given register. Granted heads are popped and
//   drive registered RF write ports one cycle later.
//
//   Handshake: a transfer on lane l happens at a rising edge where
//   valid_i[l] && ready_o[l]. ready_o depends only on FIFO state and flush_i,
//   never on valid_i. The producer may raise or drop valid_i freely.
//
// Ports
//   clk_i, arst_ni        clock, asynchronous active-low reset
//   flush_i               synchronous discard of every queued write
//   valid_i/ready_o       per-lane handshake
//   addr_i/data_i         per-lane destination register and result
//   select_r_o/data_o     registered RF write address/data per port
//   enable_writing_o      registered RF write strobe per port
//   busy_o                any entry queued or any strobe active
//   pending_addr_i/pending_o  (only when RF_WB_PENDING_EN is defined)
//                         hazard query: a write to pending_addr_i is still
//                         queued or strobing
//
// Configuration macro: RF_WB_PENDING_EN
module rf_writeback_buffer #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int LANES         = 4,
  parameter int DEPTH         = 4
) (
  input  logic                                    clk_i,
  input  logic                                    arst_ni,
  input  logic                                    flush_i,
  input  logic [LANES-1:0]                        valid_i,
  output logic [LANES-1:0]                        ready_o,
  input  logic [LANES-1:0][ADDRESS_WIDTH-1:0]     addr_i,
  input  logic [LANES-1:0][WORD_WIDTH-1:0]        data_i,
`ifdef RF_WB_PENDING_EN
  input  logic [ADDRESS_WIDTH-1:0]                pending_addr_i,
  output logic                                    pending_o,
`endif
  output logic [LANES-1:0][ADDRESS_WIDTH-1:0]     select_r_o,
  output logic [LANES-1:0][WORD_WIDTH-1:0]        data_o,
  output logic [LANES-1:0]                        enable_writing_o,
  output logic                                    busy_o
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  logic [LANES-1:0][DEPTH-1:0][ADDRESS_WIDTH-1:0] addr_mem_q, addr_mem_d;
  logic [LANES-1:0][DEPTH-1:0][WORD_WIDTH-1:0]    data_mem_q, data_mem_d;
  logic [LANES-1:0][PW-1:0]                       rptr_q, rptr_d;
  logic [LANES-1:0][PW-1:0]                       wptr_q, wptr_d;
  logic [LANES-1:0][PW:0]                         count_q, count_d;
  logic [LANES-1:0][ADDRESS_WIDTH-1:0]            sel_q, sel_d;
  logic [LANES-1:0][WORD_WIDTH-1:0]               wdata_q, wdata_d;
  logic [LANES-1:0]                               en_q, en_d;

  logic [LANES-1:0]                               not_empty, full, push, grant;
  logic [LANES-1:0][ADDRESS_WIDTH-1:0]            head_addr;
  logic [LANES-1:0][WORD_WIDTH-1:0]               head_data;

  // FIFO status and head words.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      not_empty[l] = (count_q[l] != '0);
      full[l]      = (count_q[l] == cnt_t'(DEPTH));
      head_addr[l] = addr_mem_q[l][rptr_q[l]];
      head_data[l] = data_mem_q[l][rptr_q[l]];
    end
  end

  // Lowest lane wins a same-address collision; losers keep their head.
  always_comb begin
    grant = not_empty;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < LANES; k++) begin
        if (k < l && not_empty[k] && head_addr[k] == head_addr[l]) begin
          grant[l] = 1'b0;
        end
      end
    end
  end

  // A full FIFO never accepts, even when its head pops this cycle.
  assign ready_o = ~full & {LANES{~flush_i}};
  assign push    = valid_i & ready_o;

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    en_d       = en_q;
    if (flush_i) begin
      // Flush beats push and pop; the last written address/data are kept.
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      en_d    = '0;
    end else begin
      en_d = grant;
      for (int l = 0; l < LANES; l++) begin
        if (grant[l]) begin
          rptr_d[l]  = rptr_q[l] + ptr_t'(1);
          sel_d[l]   = head_addr[l];
          wdata_d[l] = head_data[l];
        end
        if (push[l]) begin
          addr_mem_d[l][wptr_q[l]] = addr_i[l];
          data_mem_d[l][wptr_q[l]] = data_i[l];
          wptr_d[l]                = wptr_q[l] + ptr_t'(1);
        end
        count_d[l] = count_q[l] + cnt_t'(push[l]) - cnt_t'(grant[l]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      addr_mem_q <= '0;
      data_mem_q <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      en_q       <= '0;
    end else begin
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      en_q       <= en_d;
    end
  end

  assign select_r_o       = sel_q;
  assign data_o           = wdata_q;
  assign enable_writing_o = en_q;
  assign busy_o           = (|not_empty) | (|en_q);

`ifdef RF_WB_PENDING_EN
  ptr_t pend_idx;

  // Scan only the live slots of each FIFO, counted forward from the head.
  always_comb begin
    pending_o = 1'b0;
    pend_idx  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (en_q[l] && sel_q[l] == pending_addr_i) begin
        pending_o = 1'b1;
      end
      for (int j = 0; j < DEPTH; j++) begin
        pend_idx = rptr_q[l] + ptr_t'(j);
        if (cnt_t'(j) < count_q[l] && addr_mem_q[l][pend_idx] == pending_addr_i) begin
          pending_o = 1'b1;
        end
      end
    end
  end
`endif

endmodule
